// File: rtl/flit_output_arbiter.sv
// rtl/flit_output_arbiter.sv - round-robin packet-locking arbiter feeding one registered flit output stage
module flit_output_arbiter #(
    parameter int N      = 4,
    parameter int FLIT_W = 12,
    parameter int ID_W   = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [N-1:0]        q_not_empty,
    input  logic [N*FLIT_W-1:0] q_flit,
    output logic [N-1:0]        q_deq,
    output logic                out_valid,
    output logic [FLIT_W-1:0]   out_flit,
    input  logic                out_ready,
    output logic [ID_W-1:0]     grant_id,
    output logic                busy,
    output logic                proto_err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     lock_id_q, lock_id_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
    logic                proto_err_q, proto_err_d;

    logic                slot_free;
    logic                cand_found;
    logic [ID_W-1:0]     cand_id;
    logic                sel_valid;
    logic [ID_W-1:0]     sel_id;
    logic [FLIT_W-1:0]   sel_flit;
    logic                sel_head, sel_tail;
    logic                deq_fire;

    // Modulo increment that wraps at N, not at 2^ID_W.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        if (int'(v) >= N - 1) return '0;
        return v + ID_W'(1);
    endfunction

    assign slot_free = !out_valid_q || out_ready;

    // Scan from the highest offset down so the nearest non-empty queue wins.
    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (q_not_empty[(int'(rr_ptr_q) + k) % N]) begin
                cand_found = 1'b1;
                cand_id    = ID_W'((int'(rr_ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        sel_id    = (state_q == LOCKED) ? lock_id_q : cand_id;
        sel_valid = (state_q == LOCKED) ? q_not_empty[lock_id_q] : cand_found;
        sel_flit  = q_flit[int'(sel_id) * FLIT_W +: FLIT_W];
        sel_head  = sel_flit[FLIT_W-1];
        sel_tail  = sel_flit[FLIT_W-2];
        q_deq     = '0;
        if (RST_N && sel_valid && slot_free) begin
            q_deq[sel_id] = 1'b1;
        end
        deq_fire  = |q_deq;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_id_d   = lock_id_q;
        grant_id_d  = grant_id_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        proto_err_d = 1'b0;

        if (deq_fire) begin
            out_valid_d = 1'b1;
            out_flit_d  = sel_flit;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (deq_fire) begin
            unique case (state_q)
                IDLE: begin
                    grant_id_d = sel_id;
                    if (sel_head && !sel_tail) begin
                        state_d   = LOCKED;
                        lock_id_d = sel_id;
                    end else begin
                        // Single-flit packet or orphan: the packet is done either way.
                        rr_ptr_d    = wrap_inc(sel_id);
                        proto_err_d = !sel_head;
                    end
                end
                LOCKED: begin
                    proto_err_d = sel_head;
                    if (sel_tail) begin
                        state_d  = IDLE;
                        rr_ptr_d = wrap_inc(lock_id_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_id_q   <= '0;
            grant_id_q  <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_id_q   <= lock_id_d;
            grant_id_q  <= grant_id_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q == LOCKED);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_flit_output_arbiter.sv
// tb/tb_flit_output_arbiter.sv - directed and randomized checks of flit_output_arbiter against a queue-level model
module tb_flit_output_arbiter;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int IW = 2;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic [N-1:0]   q_not_empty;
    logic [N*W-1:0] q_flit;
    logic [N-1:0]   q_deq;
    logic           out_valid;
    logic [W-1:0]   out_flit;
    logic           out_ready;
    logic [IW-1:0]  grant_id;
    logic           busy;
    logic           proto_err;

    flit_output_arbiter #(.N(N), .FLIT_W(W), .ID_W(IW)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .q_not_empty (q_not_empty),
        .q_flit      (q_flit),
        .q_deq       (q_deq),
        .out_valid   (out_valid),
        .out_flit    (out_flit),
        .out_ready   (out_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    always #5 CLK = ~CLK;

    logic [W-1:0] fq [N][$];

    int checks = 0;
    int errors = 0;

    bit           m_locked;
    int           m_lock, m_rr, m_grant;
    bit           m_ov, m_perr;
    logic [W-1:0] m_of;
    logic [N-1:0] deq_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_lock = 0; m_rr = 0; m_grant = 0;
        m_ov = 0; m_perr = 0; m_of = '0;
    endtask

    task automatic drive_queues();
        for (int i = 0; i < N; i++) begin
            q_not_empty[i]  = fq[i].size() > 0;
            q_flit[i*W +: W] = (fq[i].size() > 0) ? fq[i][0] : '0;
        end
    endtask

    function automatic int exp_deq();
        if (!RST_N) return -1;
        if (m_ov && !out_ready) return -1;
        if (m_locked) return (fq[m_lock].size() > 0) ? m_lock : -1;
        for (int k = 0; k < N; k++) begin
            if (fq[(m_rr + k) % N].size() > 0) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // One clock: check q_deq before the edge, advance the model, check registered outputs after.
    task automatic step();
        int d;
        logic [N-1:0] ev;
        logic [W-1:0] f;
        drive_queues();
        #1;
        d  = exp_deq();
        ev = (d >= 0) ? (N'(1) << d) : '0;
        deq_seen = q_deq;
        check("q_deq", 32'(q_deq), 32'(ev));
        @(posedge CLK);
        if (!RST_N) begin
            model_reset();
        end else if (d >= 0) begin
            f    = fq[d].pop_front();
            m_ov = 1; m_of = f;
            if (!m_locked) begin
                m_grant = d;
                m_perr  = !f[W-1];
                if (f[W-1] && !f[W-2]) begin
                    m_locked = 1; m_lock = d;
                end else begin
                    m_rr = (d + 1) % N;
                end
            end else begin
                m_perr = f[W-1];
                if (f[W-2]) begin
                    m_locked = 0; m_rr = (m_lock + 1) % N;
                end
            end
        end else begin
            if (out_ready) m_ov = 0;
            m_perr = 0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_flit", 32'(out_flit), 32'(m_of));
        check("busy", 32'(busy), 32'(m_locked));
        check("grant_id", 32'(grant_id), 32'(m_grant));
        check("proto_err", 32'(proto_err), 32'(m_perr));
        @(negedge CLK);
    endtask

    task automatic push_packet(input int q);
        int len;
        len = $urandom_range(1, 4);
        if ($urandom_range(0, 19) == 0) begin
            fq[q].push_back({1'b0, 1'($urandom), 10'($urandom)});
        end else if (len == 1) begin
            fq[q].push_back({2'b11, 10'($urandom)});
        end else begin
            fq[q].push_back({2'b10, 10'($urandom)});
            for (int b = 0; b < len - 2; b++) fq[q].push_back({2'b00, 10'($urandom)});
            fq[q].push_back({2'b01, 10'($urandom)});
        end
    endtask

    initial begin
        out_ready = 1'b0;
        model_reset();
        step();
        step();
        RST_N = 1'b1;

        // Reset then idle with empty queues
        for (int c = 0; c < 10; c++) begin
            step();
            check("idle_deq", 32'(deq_seen), 32'h0);
            check("idle_valid", 32'(out_valid), 32'h0);
        end

        // Single-flit fairness
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) fq[i].push_back(12'hC00 | 12'(i));
        for (int i = 0; i < N; i++) begin
            step();
            check("fair_deq", 32'(deq_seen), 32'(1 << i));
            check("fair_flit", 32'(out_flit), 32'h0C00 + 32'(i));
        end
        step();

        // Packet lock on q1 while q2 waits
        fq[1].push_back(12'h801); fq[1].push_back(12'h002); fq[1].push_back(12'h403);
        fq[2].push_back(12'hC22);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lock_deq", 32'(deq_seen), 32'h2);
        end
        check("lock_tail", 32'(out_flit), 32'h403);
        step();
        check("lock_next", 32'(deq_seen), 32'h4);
        step();

        // Backpressure mid-packet
        fq[0].push_back(12'h810); fq[0].push_back(12'h011);
        fq[0].push_back(12'h012); fq[0].push_back(12'h413);
        step(); step();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_deq", 32'(deq_seen), 32'h0);
            check("bp_hold", 32'(out_flit), 32'h011);
        end
        out_ready = 1'b1;
        step();
        check("bp_resume", 32'(out_flit), 32'h012);
        step(); step();

        // Locked queue runs dry while q3 has data
        fq[0].push_back(12'h820);
        step();
        fq[3].push_back(12'hC33); fq[3].push_back(12'hC34);
        for (int c = 0; c < 3; c++) begin
            step();
            check("starve_deq", 32'(deq_seen), 32'h0);
            check("starve_busy", 32'(busy), 32'h1);
        end
        fq[0].push_back(12'h421);
        step();
        check("starve_tail", 32'(deq_seen), 32'h1);
        step();
        check("starve_q3", 32'(deq_seen), 32'h8);
        step(); step();

        // Orphan body flit in IDLE
        fq[2].push_back(12'h005);
        step();
        check("orphan_deq", 32'(deq_seen), 32'h4);
        check("orphan_err", 32'(proto_err), 32'h1);
        step();
        check("orphan_pulse", 32'(proto_err), 32'h0);

        // Reset while locked
        fq[1].push_back(12'h830); fq[1].push_back(12'h031);
        step();
        check("rst_lock", 32'(busy), 32'h1);
        RST_N = 1'b0;
        step();
        check("rst_deq", 32'(deq_seen), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        RST_N = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                int q;
                q = $urandom_range(0, N - 1);
                if (fq[q].size() < 12) push_packet(q);
            end
            RST_N = (c % 1000) != 999;
            step();
        end
        RST_N = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flit_output_arbiter.md
Name: flit_output_arbiter

Overview:
- Round-robin, packet-locking arbiter that shares one router output link between N input flit queues.
- Each queue is a 12-bit flit FIFO with enq/deq/notEmpty/notFull methods.
- Pulls flits from the granted queue via its deq strobe and registers them onto a valid/ready output stage.
- Once a head flit wins, the grant holds until that packet's tail flit has been forwarded.

Parameters:
- N, 4, number of input queues (2..8).
- FLIT_W, 12, flit width; bit FLIT_W-1 = head, bit FLIT_W-2 = tail, rest payload.
- ID_W, 2, width of the queue index; 2^ID_W >= N.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, synchronous, active-low.
- q_not_empty  in  N  notEmpty of each input queue.
- q_flit  in  N*FLIT_W  deq data of each queue; queue i at [i*FLIT_W +: FLIT_W]; valid combinationally with notEmpty.
- q_deq  out  N  one-hot-or-zero dequeue strobe to each queue; drives EN_deq.
- out_valid  out  1  registered output flit valid.
- out_flit  out  FLIT_W  registered output flit.
- out_ready  in  1  downstream accepts out_flit this cycle.
- grant_id  out  ID_W  queue currently locked, or last granted queue.
- busy  out  1  high in LOCKED.
- proto_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset values (RST_N low at a CLK edge): state IDLE, rr_ptr 0, grant_id 0, out_valid 0, out_flit 0, busy 0, proto_err 0.
- q_deq is forced to 0 while RST_N is low.
- Reset mid-packet abandons the lock. No flit is dropped or duplicated by the arbiter; the queues' own contents are untouched.
- slot_free = !out_valid || out_ready. No q_deq bit may assert unless slot_free.
- q_deq is combinational from registered state, q_not_empty, q_flit[head bits] and out_ready. It must never assert for an empty queue.
- Transfer: when q_deq[g]=1, q_flit[g] is captured into out_flit and out_valid=1 at the same edge. Latency is 1 cycle from deq to out_valid.
- Throughput is 1 flit/cycle while out_ready stays high.
- If out_valid && out_ready && no deq this cycle, out_valid goes to 0 next cycle.
- If out_valid && !out_ready, out_flit and out_valid hold unchanged and q_deq=0.

State IDLE:
- Candidate g = first i in rr_ptr, rr_ptr+1, ... (mod N) with q_not_empty[i].
- If a candidate exists and slot_free: q_deq[g]=1 and grant_id<=g.
- Head=1, tail=0: go to LOCKED, lock_id=g, busy<=1.
- Head=1, tail=1 (single-flit packet): stay IDLE, rr_ptr <= (g+1) mod N.
- Head=0 (orphan body/tail): forward it, proto_err pulse, stay IDLE, rr_ptr <= (g+1) mod N.

State LOCKED:
- Only lock_id is eligible. q_deq[lock_id]=1 iff q_not_empty[lock_id] && slot_free.
- Other queues wait even when the locked queue is empty (bubbles are allowed).
- Tail=1 forwarded: go to IDLE, busy<=0, rr_ptr <= (lock_id+1) mod N.
- Head=1 forwarded while locked: forward it, proto_err pulse, remain LOCKED.
- rr_ptr wraps from N-1 to 0 for any N, including non-powers of 2.
- rr_ptr changes only on packet completion.

Test Plan:
- Reset then idle: all queues empty -> q_deq=0, out_valid=0, busy=0, grant_id=0 for 10 cycles.
- Single-flit fairness: N=4, all queues hold one head+tail flit 0xC0i, out_ready=1.
  - Grants follow 0,1,2,3 on consecutive cycles.
  - out_flit = 0xC00, 0xC01, 0xC02, 0xC03 one cycle after each deq.
- Packet lock: q1 holds 3-flit packet 0x801, 0x002, 0x403; q2 non-empty.
  - q2 is not granted until 0x403 is forwarded; q2 is granted on the next cycle.
  - rr_ptr becomes 2.
- Backpressure: out_ready=0 for 5 cycles mid-packet.
  - out_flit is held; q_deq=0 throughout.
  - On out_ready=1, flits resume with no loss or duplication.
- Locked-queue starvation: locked q0 goes empty for 3 cycles while q3 is full.
  - q3 gets no deq; busy stays 1.
  - q0's tail arrives and is forwarded, then q3 is granted.
- Framing/reset: body flit 0x005 at the head of q2 in IDLE -> forwarded with a 1-cycle proto_err. Reset asserted while LOCKED -> state IDLE, out_valid=0 on the next edge.
